// File: rtl/lpc_capture.sv
// LPC cycle capture: filters decoded cycles by type and address window, queues them
// in a record FIFO and serialises each record as header/address/data bytes.
module lpc_capture #(
  parameter int          ADDR_BYTES = 4,
  parameter int          DEPTH_LOG2 = 5,
  parameter logic [15:0] CYC_MASK   = 16'hFFFF,
  parameter logic [31:0] ADDR_LO    = 32'h0,
  parameter logic [31:0] ADDR_HI    = 32'hFFFFFFFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear_stats,
  input  logic [3:0]            in_cyctype_dir,
  input  logic [31:0]           in_addr,
  input  logic [7:0]            in_data,
  input  logic                  in_latch,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int          DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [1:0]  AB_M1  = 2'(ADDR_BYTES - 1);
  localparam logic [31:0] SPAN   = ADDR_HI - ADDR_LO;
  localparam logic        WIN_OK = (ADDR_LO <= ADDR_HI);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_ADDR = 2'd2, S_DATA = 2'd3} state_t;

  function automatic logic [7:0] addr_byte(input logic [31:0] addr, input logic [1:0] idx);
    case (idx)
      2'd0:    return addr[7:0];
      2'd1:    return addr[15:8];
      2'd2:    return addr[23:16];
      2'd3:    return addr[31:24];
      default: return addr[7:0];
    endcase
  endfunction

  function automatic logic [7:0] header(input logic lost, input logic [3:0] cyc);
    return {1'b1, lost, cyc, AB_M1};
  endfunction

  // Entry layout: [44] lost, [43:40] cyctype_dir, [39:8] addr, [7:0] data
  logic [44:0]           mem_r [DEPTH];
  logic [DEPTH_LOG2:0]   wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s;
  logic                  pending_lost_r;
  state_t                state_r;
  logic [44:0]           hold_r;
  logic [1:0]            idx_r;
  logic [7:0]            out_data_r;
  logic                  out_valid_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic                  empty_r;
  logic                  overflow_r;
  logic [7:0]            drop_count_r;
  logic                  accept_s, full_s, fifo_empty_s, pop_s, drop_s, write_s;
  logic [44:0]           rd_entry_s;

  // Filter, FIFO status and push/pop/drop decisions
  always_comb begin
    accept_s     = 1'b0;
    full_s       = 1'b0;
    fifo_empty_s = 1'b0;
    pop_s        = 1'b0;
    drop_s       = 1'b0;
    write_s      = 1'b0;
    accept_s     = in_latch & enable & WIN_OK & CYC_MASK[in_cyctype_dir] &
                   ((in_addr - ADDR_LO) <= SPAN);
    full_s       = (wptr_r[DEPTH_LOG2] != rptr_r[DEPTH_LOG2]) &&
                   (wptr_r[DEPTH_LOG2-1:0] == rptr_r[DEPTH_LOG2-1:0]);
    fifo_empty_s = (wptr_r == rptr_r);
    pop_s        = (state_r == S_IDLE) && !fifo_empty_s;
    // A same-cycle pop frees a slot, so a push into a full FIFO still fits
    drop_s       = accept_s && full_s && !pop_s;
    write_s      = accept_s && !drop_s;
    wptr_nxt_s   = wptr_r + {{DEPTH_LOG2{1'b0}}, write_s};
    rptr_nxt_s   = rptr_r + {{DEPTH_LOG2{1'b0}}, pop_s};
    rd_entry_s   = mem_r[rptr_r[DEPTH_LOG2-1:0]];
  end

  // Record storage; contents are qualified by the pointers, so no reset needed
  always_ff @(posedge clock) begin
    if (write_s) begin
      mem_r[wptr_r[DEPTH_LOG2-1:0]] <= {pending_lost_r, in_cyctype_dir, in_addr, in_data};
    end
  end

  // Pointers, occupancy and loss statistics
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_r         <= '0;
      rptr_r         <= '0;
      level_r        <= '0;
      empty_r        <= 1'b1;
      overflow_r     <= 1'b0;
      drop_count_r   <= 8'h00;
      pending_lost_r <= 1'b0;
    end else begin
      wptr_r  <= wptr_nxt_s;
      rptr_r  <= rptr_nxt_s;
      level_r <= wptr_nxt_s - rptr_nxt_s;
      empty_r <= (wptr_nxt_s == rptr_nxt_s);
      if (drop_s) begin
        overflow_r     <= 1'b1;
        pending_lost_r <= 1'b1;
        drop_count_r   <= clear_stats ? 8'h01 :
                          ((drop_count_r == 8'hFF) ? 8'hFF : drop_count_r + 8'h01);
      end else begin
        if (write_s) pending_lost_r <= 1'b0;
        if (clear_stats) begin
          overflow_r   <= 1'b0;
          drop_count_r <= 8'h00;
        end
      end
    end
  end

  // Serialiser: IDLE pops a record, then HDR, ADDR bytes MSB-first, DATA
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      hold_r      <= '0;
      idx_r       <= 2'd0;
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            hold_r      <= rd_entry_s;
            state_r     <= S_HDR;
            out_valid_r <= 1'b1;
            out_data_r  <= header(rd_entry_s[44], rd_entry_s[43:40]);
          end
        end
        S_HDR: begin
          if (out_ready) begin
            state_r    <= S_ADDR;
            idx_r      <= AB_M1;
            out_data_r <= addr_byte(hold_r[39:8], AB_M1);
          end
        end
        S_ADDR: begin
          if (out_ready) begin
            if (idx_r == 2'd0) begin
              state_r    <= S_DATA;
              out_data_r <= hold_r[7:0];
            end else begin
              idx_r      <= idx_r - 2'd1;
              out_data_r <= addr_byte(hold_r[39:8], idx_r - 2'd1);
            end
          end
        end
        S_DATA: begin
          if (out_ready) begin
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          out_valid_r <= 1'b0;
          out_data_r  <= 8'h00;
        end
      endcase
    end
  end

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign level      = level_r;
  assign empty      = empty_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_lpc_capture.sv
// Randomised and directed bench for lpc_capture, checked against a record-level
// queue model of the filter, FIFO, loss marking and byte stream.
module tb_lpc_capture;

  localparam int          DEPTH = 4;
  localparam logic [15:0] MASK  = 16'h00F4;
  localparam logic [31:0] LO    = 32'h80;
  localparam logic [31:0] HI    = 32'h8F;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        clear_stats = 1'b0;
  logic [3:0]  in_cyctype_dir = 4'h0;
  logic [31:0] in_addr = 32'h0;
  logic [7:0]  in_data = 8'h00;
  logic        in_latch = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  level;
  logic        empty;
  logic        overflow;
  logic [7:0]  drop_count;

  lpc_capture #(
    .ADDR_BYTES(4), .DEPTH_LOG2(2), .CYC_MASK(MASK), .ADDR_LO(LO), .ADDR_HI(HI)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear_stats(clear_stats),
    .in_cyctype_dir(in_cyctype_dir), .in_addr(in_addr), .in_data(in_data),
    .in_latch(in_latch), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .empty(empty), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass = 0;
  int cyc_cnt = 0;
  int first_valid = -1;

  // Model state
  logic [44:0] m_fifo[$];
  logic [7:0]  m_bytes[$];
  logic [7:0]  seen[$];
  bit          m_pend = 1'b0;
  bit          m_ovf = 1'b0;
  int          m_drops = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_cnt);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_bytes.delete();
    m_pend = 1'b0;
    m_ovf = 1'b0;
    m_drops = 0;
  endtask

  // One clock: compare outputs mid-cycle, advance the model, then pass the edge
  task automatic cycle();
    bit acc, full, pop;
    logic [44:0] rec;
    @(negedge clock);
    check_val("out_valid", out_valid, m_bytes.size() > 0);
    if (m_bytes.size() > 0) check_val("out_data", out_data, m_bytes[0]);
    check_val("level", level, m_fifo.size());
    check_val("empty", empty, m_fifo.size() == 0);
    check_val("overflow", overflow, m_ovf);
    check_val("drop_count", drop_count, m_drops);
    if (out_valid && out_ready) seen.push_back(out_data);
    if (out_valid && first_valid < 0) first_valid = cyc_cnt;

    acc  = in_latch && enable && MASK[in_cyctype_dir] && in_addr >= LO && in_addr <= HI;
    full = (m_fifo.size() == DEPTH);
    pop  = (m_bytes.size() == 0) && (m_fifo.size() > 0);
    if (m_bytes.size() > 0 && out_ready) void'(m_bytes.pop_front());
    if (pop) begin
      rec = m_fifo.pop_front();
      m_bytes.push_back({1'b1, rec[44], rec[43:40], 2'd3});
      m_bytes.push_back(rec[39:32]);
      m_bytes.push_back(rec[31:24]);
      m_bytes.push_back(rec[23:16]);
      m_bytes.push_back(rec[15:8]);
      m_bytes.push_back(rec[7:0]);
    end
    if (acc && full && !pop) begin
      m_drops = clear_stats ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
      m_ovf = 1'b1;
      m_pend = 1'b1;
    end else begin
      if (acc) begin
        m_fifo.push_back({m_pend, in_cyctype_dir, in_addr, in_data});
        m_pend = 1'b0;
      end
      if (clear_stats) begin
        m_drops = 0;
        m_ovf = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    cyc_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic strobe(input logic [3:0] c, input logic [31:0] a, input logic [7:0] d);
    in_latch = 1'b1;
    in_cyctype_dir = c;
    in_addr = a;
    in_data = d;
    cycle();
    in_latch = 1'b0;
  endtask

  logic [7:0] exp1 [6] = '{8'h8B, 8'h00, 8'h00, 8'h00, 8'h80, 8'h55};
  logic [7:0] exp2 [6] = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h8A, 8'hC3};

  initial begin
    int strobe_cyc;
    int c_sel;
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_data", out_data, 8'h00);
    check_val("rst_level", level, 3'd0);
    check_val("rst_empty", empty, 1'b1);
    check_val("rst_overflow", overflow, 1'b0);
    check_val("rst_drop_count", drop_count, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Single record latency and byte order
    seen.delete();
    first_valid = -1;
    strobe_cyc = cyc_cnt;
    strobe(4'h2, 32'h00000080, 8'h55);
    idle(10);
    check_val("single_latency", first_valid - strobe_cyc, 2);
    check_val("single_len", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) check_val("single_byte", seen[i], exp1[i]);

    // Backpressure: ready toggles every cycle
    seen.delete();
    out_ready = 1'b0;
    strobe(4'h4, 32'h0000008A, 8'hC3);
    for (int i = 0; i < 16; i++) begin
      out_ready = i[0];
      cycle();
    end
    out_ready = 1'b1;
    idle(4);
    check_val("bp_len", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) check_val("bp_byte", seen[i], exp2[i]);

    // Filter window and cycle-type mask
    seen.delete();
    strobe(4'h2, 32'h7F, 8'h01);
    strobe(4'h2, 32'h80, 8'h02);
    strobe(4'h2, 32'h8F, 8'h03);
    strobe(4'h2, 32'h90, 8'h04);
    strobe(4'h1, 32'h85, 8'h05);
    idle(30);
    check_val("filter_bytes", seen.size(), 12);
    check_val("filter_drops", drop_count, 8'h00);

    // Overflow: one record sits in the serialiser, four fill the FIFO, two drop
    seen.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) strobe(4'h2, 32'h80 + i, 8'(i));
    check_val("ovf_level", level, 3'd4);
    check_val("ovf_flag", overflow, 1'b1);
    check_val("ovf_drops", drop_count, 8'd2);
    out_ready = 1'b1;
    idle(8);
    strobe(4'h2, 32'h8E, 8'hAA);
    idle(60);
    check_val("ovf_bytes", seen.size(), 36);
    for (int k = 0; k < 6 && 6 * k < seen.size(); k++)
      check_val("ovf_lost_bit", seen[6 * k][6], k == 5);

    // Drop counter saturation and clear coinciding with a drop
    clear_stats = 1'b1;
    cycle();
    clear_stats = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 305; i++) strobe(4'h5, 32'h88, 8'(i));
    check_val("sat_drops", drop_count, 8'hFF);
    clear_stats = 1'b1;
    strobe(4'h5, 32'h88, 8'h11);
    clear_stats = 1'b0;
    check_val("clr_drop_drops", drop_count, 8'd1);
    check_val("clr_drop_ovf", overflow, 1'b1);
    out_ready = 1'b1;
    idle(60);

    // Reset in the middle of a record
    seen.delete();
    strobe(4'h6, 32'h84, 8'h21);
    strobe(4'h7, 32'h85, 8'h22);
    for (int i = 0; i < 20 && seen.size() < 2; i++) cycle();
    check_val("mid_reset_reached", seen.size(), 2);
    reset = 1'b0;
    #1;
    check_val("mid_reset_valid", out_valid, 1'b0);
    check_val("mid_reset_level", level, 3'd0);
    check_val("mid_reset_empty", empty, 1'b1);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    seen.delete();
    strobe(4'h2, 32'h00000080, 8'h55);
    idle(10);
    check_val("post_reset_len", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) check_val("post_reset_byte", seen[i], exp1[i]);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      enable = ($urandom % 8) != 0;
      in_latch = $urandom % 2;
      c_sel = $urandom % 3;
      in_cyctype_dir = (c_sel == 0) ? 4'h2 : ((c_sel == 1) ? 4'h4 : 4'($urandom));
      in_addr = 32'h78 + ($urandom % 32);
      in_data = 8'($urandom);
      out_ready = (i % 400 < 200) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
      clear_stats = ($urandom % 64) == 0;
      cycle();
    end
    in_latch = 1'b0;
    clear_stats = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    idle(60);
    check_val("final_empty", empty, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
